// File: rtl/xor_chan_pkg.sv
// Shared types and default sizing for the per-channel XOR / accumulate array.
// Optional accumulate feature is enabled by defining XOR_CHAN_ARRAY_ACC_EN.
package xor_chan_pkg;

    typedef enum logic {
        XOR_MODE = 1'b0,
        ACC_MODE = 1'b1
    } mode_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 2;

    // Pointer width that still gives one bit when DEPTH is 1.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xor_chan.sv
// One channel: XOR / accumulate datapath feeding a DEPTH-entry output FIFO.
// Accumulator exists only when XOR_CHAN_ARRAY_ACC_EN is defined.
module xor_chan
    import xor_chan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_bits(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_result;

    // Explicit wrap keeps non power-of-two depths in range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_mem[r_rptr];

`ifdef XOR_CHAN_ARRAY_ACC_EN
    logic [WIDTH-1:0] r_acc;
    logic             w_acc_mode;
    logic [WIDTH-1:0] w_acc_base;

    assign w_acc_mode = (mode_e'(mode) == ACC_MODE);

    // Clear takes effect before the accumulate of the same cycle.
    always_comb begin
        w_acc_base = acc_clr ? {WIDTH{1'b0}} : r_acc;
        if (w_acc_mode) begin
            w_result = w_acc_base ^ a ^ b;
        end else begin
            w_result = a ^ b;
        end
    end

    // Accumulator register: loads on a mode-1 accept, otherwise clears or holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (w_push && w_acc_mode) begin
            r_acc <= w_result;
        end else if (acc_clr) begin
            r_acc <= {WIDTH{1'b0}};
        end else begin
            r_acc <= r_acc;
        end
    end
`else
    logic w_unused;
    assign w_unused = mode ^ acc_clr;
    assign w_result = a ^ b;
`endif

    // Next occupancy from push/pop; both together leave it unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr] <= w_result;
        end
    end

    // Pointers, count and the registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= {PW{1'b0}};
            r_rptr      <= {PW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= (w_cnt_nxt < FULL_CNT);
            r_out_valid <= (w_cnt_nxt != {CW{1'b0}});
        end
    end

endmodule

// File: rtl/xor_chan_array.sv
// CHANNELS independent xor_chan instances on packed buses.
// Accumulate mode is built in only when XOR_CHAN_ARRAY_ACC_EN is defined.
module xor_chan_array
    import xor_chan_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       acc_clr,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] c
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        xor_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .a         (a[k*WIDTH +: WIDTH]),
            .b         (b[k*WIDTH +: WIDTH]),
            .mode      (mode[k]),
            .acc_clr   (acc_clr[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .c         (c[k*WIDTH +: WIDTH])
        );
    end

endmodule
